// File: rtl/branch_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_issue_queue
// Desc     : In-order issue queue for the branch execution unit. Buffers
//            dispatched branch/jump ops, captures source operands from
//            dispatch or the writeback bus, and issues one op per cycle
//            from the head once both operands are ready. Self-flushes on
//            BEU redirect or global flush.
// Revision : 1.0 - initial release
// ============================================================================
module branch_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   disp_valid_i,
  output logic                   disp_ready_o,
  input  logic [63:0]            disp_pc_i,
  input  logic [31:0]            disp_inst_i,
  input  logic [3:0]             disp_func_code_i,
  input  logic                   disp_rs1_rdy_i,
  input  logic                   disp_rs2_rdy_i,
  input  logic [TAG_W-1:0]       disp_rs1_tag_i,
  input  logic [TAG_W-1:0]       disp_rs2_tag_i,
  input  logic [63:0]            disp_rs1_value_i,
  input  logic [63:0]            disp_rs2_value_i,
  input  logic                   wb_valid_i,
  input  logic [TAG_W-1:0]       wb_tag_i,
  input  logic [63:0]            wb_value_i,
  input  logic                   redirect_i,
  input  logic                   flush_i,
  output logic                   branch_valid_o,
  output logic [63:0]            branch_pc_o,
  output logic [31:0]            branch_inst_o,
  output logic [63:0]            rs1_value_o,
  output logic [63:0]            rs2_value_o,
  output logic [3:0]             func_code_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Entry storage
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [63:0]      pc_q      [DEPTH];
  logic [63:0]      pc_d      [DEPTH];
  logic [31:0]      inst_q    [DEPTH];
  logic [31:0]      inst_d    [DEPTH];
  logic [3:0]       func_q    [DEPTH];
  logic [3:0]       func_d    [DEPTH];
  logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
  logic [TAG_W-1:0] rs1_tag_q [DEPTH];
  logic [TAG_W-1:0] rs1_tag_d [DEPTH];
  logic [TAG_W-1:0] rs2_tag_q [DEPTH];
  logic [TAG_W-1:0] rs2_tag_d [DEPTH];
  logic [63:0]      rs1_val_q [DEPTH];
  logic [63:0]      rs1_val_d [DEPTH];
  logic [63:0]      rs2_val_q [DEPTH];
  logic [63:0]      rs2_val_d [DEPTH];

  // Pointers carry an extra wrap bit above the index
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             kill;
  logic             disp_fire;
  logic             issue;
  logic             disp_wb_hit1;
  logic             disp_wb_hit2;

  assign head_idx  = head_q[IDX_W-1:0];
  assign tail_idx  = tail_q[IDX_W-1:0];
  assign full      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign kill      = redirect_i | flush_i;

  // Ready depends only on occupancy so dispatch never waits on issue timing
  assign disp_ready_o = ~full;
  assign disp_fire    = disp_valid_i & ~full & ~kill;

  // The younger op behind a redirecting branch must never reach the BEU
  assign issue          = valid_q[head_idx] & rs1_rdy_q[head_idx] & rs2_rdy_q[head_idx];
  assign branch_valid_o = issue & ~kill;

  assign branch_pc_o   = pc_q[head_idx];
  assign branch_inst_o = inst_q[head_idx];
  assign func_code_o   = func_q[head_idx];
  assign rs1_value_o   = rs1_val_q[head_idx];
  assign rs2_value_o   = rs2_val_q[head_idx];

  assign count_o = tail_q - head_q;

  // A writeback landing in the dispatch cycle counts as ready at dispatch
  assign disp_wb_hit1 = wb_valid_i && (wb_tag_i == disp_rs1_tag_i);
  assign disp_wb_hit2 = wb_valid_i && (wb_tag_i == disp_rs2_tag_i);

  // Next-state: flush, wakeup, head retire and tail allocate
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    func_d    = func_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    head_d    = head_q;
    tail_d    = tail_q;

    if (kill) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid_i && valid_q[i]) begin
          if (!rs1_rdy_q[i] && (rs1_tag_q[i] == wb_tag_i)) begin
            rs1_rdy_d[i] = 1'b1;
            rs1_val_d[i] = wb_value_i;
          end
          if (!rs2_rdy_q[i] && (rs2_tag_q[i] == wb_tag_i)) begin
            rs2_rdy_d[i] = 1'b1;
            rs2_val_d[i] = wb_value_i;
          end
        end
      end

      if (issue) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_W'(1);
      end

      // The tail slot can only alias the head when the queue is empty
      // (head invalid) or full (dispatch refused), so no conflict with issue
      if (disp_fire) begin
        valid_d[tail_idx]   = 1'b1;
        pc_d[tail_idx]      = disp_pc_i;
        inst_d[tail_idx]    = disp_inst_i;
        func_d[tail_idx]    = disp_func_code_i;
        rs1_tag_d[tail_idx] = disp_rs1_tag_i;
        rs2_tag_d[tail_idx] = disp_rs2_tag_i;
        rs1_rdy_d[tail_idx] = disp_rs1_rdy_i | disp_wb_hit1;
        rs2_rdy_d[tail_idx] = disp_rs2_rdy_i | disp_wb_hit2;
        rs1_val_d[tail_idx] = disp_rs1_rdy_i ? disp_rs1_value_i : wb_value_i;
        rs2_val_d[tail_idx] = disp_rs2_rdy_i ? disp_rs2_value_i : wb_value_i;
        tail_d              = tail_q + PTR_W'(1);
      end
    end
  end

  // State registers; data cleared on reset so idle outputs read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]      <= '0;
        inst_q[i]    <= '0;
        func_q[i]    <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      func_q    <= func_d;
      rs1_tag_q <= rs1_tag_d;
      rs2_tag_q <= rs2_tag_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_issue_queue
// Desc     : Self-checking bench for branch_issue_queue with directed
//            scenarios and a randomized run against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             disp_valid_i;
  logic             disp_ready_o;
  logic [63:0]      disp_pc_i;
  logic [31:0]      disp_inst_i;
  logic [3:0]       disp_func_code_i;
  logic             disp_rs1_rdy_i, disp_rs2_rdy_i;
  logic [TAG_W-1:0] disp_rs1_tag_i, disp_rs2_tag_i;
  logic [63:0]      disp_rs1_value_i, disp_rs2_value_i;
  logic             wb_valid_i;
  logic [TAG_W-1:0] wb_tag_i;
  logic [63:0]      wb_value_i;
  logic             redirect_i, flush_i;
  logic             branch_valid_o;
  logic [63:0]      branch_pc_o;
  logic [31:0]      branch_inst_o;
  logic [63:0]      rs1_value_o, rs2_value_o;
  logic [3:0]       func_code_o;
  logic [PTR_W-1:0] count_o;

  always #5 clk = ~clk;

  branch_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_pc_i(disp_pc_i), .disp_inst_i(disp_inst_i),
    .disp_func_code_i(disp_func_code_i),
    .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
    .disp_rs1_tag_i(disp_rs1_tag_i), .disp_rs2_tag_i(disp_rs2_tag_i),
    .disp_rs1_value_i(disp_rs1_value_i), .disp_rs2_value_i(disp_rs2_value_i),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_value_i(wb_value_i),
    .redirect_i(redirect_i), .flush_i(flush_i),
    .branch_valid_o(branch_valid_o), .branch_pc_o(branch_pc_o),
    .branch_inst_o(branch_inst_o), .rs1_value_o(rs1_value_o),
    .rs2_value_o(rs2_value_o), .func_code_o(func_code_o), .count_o(count_o)
  );

  // Reference model: an ordered list of queued ops
  typedef struct packed {
    logic [63:0]      pc;
    logic [31:0]      inst;
    logic [3:0]       func;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [63:0]      v1;
    logic             r2;
    logic [TAG_W-1:0] t2;
    logic [63:0]      v2;
  } ent_t;

  ent_t mq[$];

  int checks = 0;
  int errors = 0;

  logic             exp_valid, exp_ready;
  logic [PTR_W-1:0] exp_count;
  logic [63:0]      exp_pc, exp_rs1, exp_rs2;
  logic [31:0]      exp_inst;
  logic [3:0]       exp_func;

  // Expected outputs for the current inputs and model contents
  function void model_expect();
    exp_ready = (mq.size() < DEPTH);
    exp_count = PTR_W'(mq.size());
    exp_valid = 1'b0;
    exp_pc = '0; exp_inst = '0; exp_func = '0; exp_rs1 = '0; exp_rs2 = '0;
    if (mq.size() > 0) begin
      exp_valid = mq[0].r1 && mq[0].r2 && !redirect_i && !flush_i;
      exp_pc    = mq[0].pc;
      exp_inst  = mq[0].inst;
      exp_func  = mq[0].func;
      exp_rs1   = mq[0].v1;
      exp_rs2   = mq[0].v2;
    end
  endfunction

  // Advance the model by one clock edge using the inputs held across it
  function void model_edge();
    ent_t e;
    bit   iss, acc;
    if (!rst_n || redirect_i || flush_i) begin
      mq.delete();
      return;
    end
    iss = (mq.size() > 0) && mq[0].r1 && mq[0].r2;
    acc = disp_valid_i && (mq.size() < DEPTH);
    if (iss) void'(mq.pop_front());
    if (wb_valid_i) begin
      foreach (mq[i]) begin
        e = mq[i];
        if (!e.r1 && e.t1 == wb_tag_i) begin e.r1 = 1'b1; e.v1 = wb_value_i; end
        if (!e.r2 && e.t2 == wb_tag_i) begin e.r2 = 1'b1; e.v2 = wb_value_i; end
        mq[i] = e;
      end
    end
    if (acc) begin
      e.pc   = disp_pc_i;
      e.inst = disp_inst_i;
      e.func = disp_func_code_i;
      e.t1   = disp_rs1_tag_i;
      e.t2   = disp_rs2_tag_i;
      e.r1   = disp_rs1_rdy_i || (wb_valid_i && wb_tag_i == disp_rs1_tag_i);
      e.r2   = disp_rs2_rdy_i || (wb_valid_i && wb_tag_i == disp_rs2_tag_i);
      e.v1   = disp_rs1_rdy_i ? disp_rs1_value_i : wb_value_i;
      e.v2   = disp_rs2_rdy_i ? disp_rs2_value_i : wb_value_i;
      mq.push_back(e);
    end
  endfunction

  task automatic idle();
    disp_valid_i = 1'b0; disp_pc_i = '0; disp_inst_i = '0; disp_func_code_i = '0;
    disp_rs1_rdy_i = 1'b0; disp_rs2_rdy_i = 1'b0;
    disp_rs1_tag_i = '0; disp_rs2_tag_i = '0;
    disp_rs1_value_i = '0; disp_rs2_value_i = '0;
    wb_valid_i = 1'b0; wb_tag_i = '0; wb_value_i = '0;
    redirect_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic set_disp(input logic [63:0] pc, input logic [3:0] func,
                          input logic r1, input logic [TAG_W-1:0] t1, input logic [63:0] v1,
                          input logic r2, input logic [TAG_W-1:0] t2, input logic [63:0] v2);
    disp_valid_i = 1'b1; disp_pc_i = pc; disp_inst_i = $urandom(); disp_func_code_i = func;
    disp_rs1_rdy_i = r1; disp_rs1_tag_i = t1; disp_rs1_value_i = v1;
    disp_rs2_rdy_i = r2; disp_rs2_tag_i = t2; disp_rs2_value_i = v2;
  endtask

  // Clock edge, model update, then back to the falling edge for new inputs
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    mq.delete();
    #2;
    checks++; if (branch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", branch_valid_o); end
    checks++; if (disp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", disp_ready_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (branch_pc_o !== 64'd0 || rs1_value_o !== 64'd0 || rs2_value_o !== 64'd0 ||
                  branch_inst_o !== 32'd0 || func_code_o !== 4'd0) begin
      errors++; $display("FAIL reset_data: got pc=%h rs1=%h rs2=%h inst=%h func=%h expected all 0",
                         branch_pc_o, rs1_value_o, rs2_value_o, branch_inst_o, func_code_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_jal();
    set_disp(64'h1000, 4'b0111, 1'b1, '0, 64'h11, 1'b1, '0, 64'h22);
    settle();
    checks++; if (branch_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL jal_dispatch_cycle: got valid=%b count=%0d expected 0/0", branch_valid_o, count_o); end
    cyc(); idle(); settle();
    checks++; if (branch_valid_o !== 1'b1 || branch_pc_o !== 64'h1000 || func_code_o !== 4'b0111) begin
      errors++; $display("FAIL jal_issue: got valid=%b pc=%h func=%h expected 1/1000/7", branch_valid_o, branch_pc_o, func_code_o); end
    checks++; if (rs1_value_o !== 64'h11 || rs2_value_o !== 64'h22 || count_o !== 3'd1) begin
      errors++; $display("FAIL jal_operands: got rs1=%h rs2=%h count=%0d expected 11/22/1", rs1_value_o, rs2_value_o, count_o); end
    cyc(); settle();
    checks++; if (branch_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL jal_drained: got valid=%b count=%0d expected 0/0", branch_valid_o, count_o); end
  endtask

  task automatic test_wakeup();
    set_disp(64'h2000, 4'b0100, 1'b0, 5'd7, 64'hDEAD, 1'b1, '0, 64'h99);
    cyc(); idle(); settle();
    checks++; if (branch_valid_o !== 1'b0) begin errors++; $display("FAIL wake_early1: got %b expected 0", branch_valid_o); end
    cyc(); settle();
    checks++; if (branch_valid_o !== 1'b0) begin errors++; $display("FAIL wake_early2: got %b expected 0", branch_valid_o); end
    wb_valid_i = 1'b1; wb_tag_i = 5'd7; wb_value_i = 64'h55;
    settle();
    checks++; if (branch_valid_o !== 1'b0) begin errors++; $display("FAIL wake_no_bypass: got %b expected 0", branch_valid_o); end
    cyc(); idle(); settle();
    checks++; if (branch_valid_o !== 1'b1 || rs1_value_o !== 64'h55 || rs2_value_o !== 64'h99 || branch_pc_o !== 64'h2000) begin
      errors++; $display("FAIL wake_issue: got valid=%b rs1=%h rs2=%h pc=%h expected 1/55/99/2000",
                         branch_valid_o, rs1_value_o, rs2_value_o, branch_pc_o); end
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_disp(64'h3000 + 64'(4 * i), 4'b0111, 1'b1, '0, 64'(i), 1'b1, '0, 64'(i + 8));
      settle();
      if (i > 0) begin
        checks++; if (branch_valid_o !== 1'b1 || branch_pc_o !== 64'h3000 + 64'(4 * (i - 1))) begin
          errors++; $display("FAIL b2b_issue%0d: got valid=%b pc=%h expected 1/%h", i, branch_valid_o, branch_pc_o,
                             64'h3000 + 64'(4 * (i - 1))); end
      end
      cyc();
    end
    idle(); settle();
    checks++; if (branch_valid_o !== 1'b1 || branch_pc_o !== 64'h300C) begin
      errors++; $display("FAIL b2b_last: got valid=%b pc=%h expected 1/300c", branch_valid_o, branch_pc_o); end
    cyc(); settle();
    checks++; if (branch_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL b2b_empty: got valid=%b count=%0d expected 0/0", branch_valid_o, count_o); end
  endtask

  task automatic test_full_stall();
    set_disp(64'h4000, 4'b0100, 1'b0, 5'd9, '0, 1'b1, '0, 64'h1);
    cyc();
    for (int i = 1; i < 4; i++) begin
      set_disp(64'h4000 + 64'(4 * i), 4'b0101, 1'b1, '0, 64'(i), 1'b1, '0, 64'(i));
      cyc();
    end
    idle(); settle();
    checks++; if (count_o !== 3'd4 || disp_ready_o !== 1'b0 || branch_valid_o !== 1'b0) begin
      errors++; $display("FAIL full_state: got count=%0d ready=%b valid=%b expected 4/0/0", count_o, disp_ready_o, branch_valid_o); end
    set_disp(64'h4010, 4'b0111, 1'b1, '0, '0, 1'b1, '0, '0);
    wb_valid_i = 1'b1; wb_tag_i = 5'd9; wb_value_i = 64'h909;
    settle();
    checks++; if (disp_ready_o !== 1'b0 || branch_valid_o !== 1'b0) begin
      errors++; $display("FAIL full_refuse: got ready=%b valid=%b expected 0/0", disp_ready_o, branch_valid_o); end
    cyc();
    wb_valid_i = 1'b0; settle();
    checks++; if (count_o !== 3'd4 || branch_valid_o !== 1'b1 || branch_pc_o !== 64'h4000 || rs1_value_o !== 64'h909) begin
      errors++; $display("FAIL full_head_issue: got count=%0d valid=%b pc=%h rs1=%h expected 4/1/4000/909",
                         count_o, branch_valid_o, branch_pc_o, rs1_value_o); end
    cyc(); idle(); settle();
    checks++; if (count_o !== 3'd3 || disp_ready_o !== 1'b1 || branch_pc_o !== 64'h4004) begin
      errors++; $display("FAIL full_after_issue: got count=%0d ready=%b pc=%h expected 3/1/4004", count_o, disp_ready_o, branch_pc_o); end
    for (int k = 2; k < 4; k++) begin
      cyc(); settle();
      checks++; if (branch_valid_o !== 1'b1 || branch_pc_o !== 64'h4000 + 64'(4 * k)) begin
        errors++; $display("FAIL full_drain%0d: got valid=%b pc=%h expected 1/%h", k, branch_valid_o, branch_pc_o,
                           64'h4000 + 64'(4 * k)); end
    end
    cyc(); settle();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", count_o); end
  endtask

  task automatic test_redirect();
    set_disp(64'h5000, 4'b0100, 1'b1, '0, 64'hA, 1'b1, '0, 64'hA);
    cyc();
    set_disp(64'h5004, 4'b0100, 1'b1, '0, 64'hB, 1'b1, '0, 64'hB);
    settle();
    checks++; if (branch_valid_o !== 1'b1 || branch_pc_o !== 64'h5000) begin
      errors++; $display("FAIL redir_a_issue: got valid=%b pc=%h expected 1/5000", branch_valid_o, branch_pc_o); end
    cyc();
    set_disp(64'h5008, 4'b0111, 1'b1, '0, 64'hC, 1'b1, '0, 64'hC);
    redirect_i = 1'b1;
    settle();
    checks++; if (branch_valid_o !== 1'b0 || count_o !== 3'd1) begin
      errors++; $display("FAIL redir_suppress: got valid=%b count=%0d expected 0/1", branch_valid_o, count_o); end
    cyc(); idle(); settle();
    checks++; if (count_o !== 3'd0 || disp_ready_o !== 1'b1 || branch_valid_o !== 1'b0) begin
      errors++; $display("FAIL redir_empty: got count=%0d ready=%b valid=%b expected 0/1/0", count_o, disp_ready_o, branch_valid_o); end
    cyc(); settle();
    checks++; if (branch_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL redir_drop: got valid=%b count=%0d expected 0/0", branch_valid_o, count_o); end
  endtask

  task automatic test_dispatch_bypass();
    set_disp(64'h6000, 4'b0101, 1'b1, '0, 64'h77, 1'b0, 5'd3, 64'hBAD);
    wb_valid_i = 1'b1; wb_tag_i = 5'd3; wb_value_i = 64'hABCD;
    cyc(); idle(); settle();
    checks++; if (branch_valid_o !== 1'b1 || rs2_value_o !== 64'hABCD || rs1_value_o !== 64'h77 || func_code_o !== 4'b0101) begin
      errors++; $display("FAIL bypass_issue: got valid=%b rs2=%h rs1=%h func=%h expected 1/abcd/77/5",
                         branch_valid_o, rs2_value_o, rs1_value_o, func_code_o); end
    cyc();
  endtask

  task automatic test_wrap_and_reset();
    for (int i = 0; i < 10; i++) begin
      set_disp(64'h7000 + 64'(4 * i), 4'b0111, 1'b1, '0, 64'(i), 1'b1, '0, 64'(i));
      settle();
      if (i > 0) begin
        checks++; if (count_o !== 3'd1 || branch_valid_o !== 1'b1 || branch_pc_o !== 64'h7000 + 64'(4 * (i - 1))) begin
          errors++; $display("FAIL wrap_%0d: got count=%0d valid=%b pc=%h expected 1/1/%h", i, count_o, branch_valid_o,
                             branch_pc_o, 64'h7000 + 64'(4 * (i - 1))); end
      end
      cyc();
    end
    set_disp(64'h8000, 4'b0100, 1'b0, 5'd11, '0, 1'b1, '0, '0);
    cyc();
    set_disp(64'h8004, 4'b0100, 1'b0, 5'd11, '0, 1'b1, '0, '0);
    cyc(); idle(); settle();
    checks++; if (count_o !== 3'd2 || exp_count !== count_o) begin
      errors++; $display("FAIL wrap_partial: got count=%0d expected 2", count_o); end
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    checks++; if (count_o !== 3'd0 || branch_valid_o !== 1'b0 || disp_ready_o !== 1'b1 || branch_pc_o !== 64'd0) begin
      errors++; $display("FAIL async_reset: got count=%0d valid=%b ready=%b pc=%h expected 0/0/1/0",
                         count_o, branch_valid_o, disp_ready_o, branch_pc_o); end
    @(negedge clk);
    rst_n = 1'b1;
    wb_valid_i = 1'b1; wb_tag_i = 5'd11; wb_value_i = 64'h1111;
    cyc(); idle(); settle();
    checks++; if (branch_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL post_reset_idle: got valid=%b count=%0d expected 0/0", branch_valid_o, count_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      disp_valid_i     = ($urandom_range(0, 9) < 6);
      disp_pc_i        = {$urandom(), $urandom()};
      disp_inst_i      = $urandom();
      case ($urandom_range(0, 2))
        0:       disp_func_code_i = 4'b0100;
        1:       disp_func_code_i = 4'b0101;
        default: disp_func_code_i = 4'b0111;
      endcase
      disp_rs1_rdy_i   = 1'($urandom_range(0, 1));
      disp_rs2_rdy_i   = 1'($urandom_range(0, 1));
      disp_rs1_tag_i   = TAG_W'($urandom_range(0, 7));
      disp_rs2_tag_i   = TAG_W'($urandom_range(0, 7));
      disp_rs1_value_i = {$urandom(), $urandom()};
      disp_rs2_value_i = {$urandom(), $urandom()};
      wb_valid_i       = ($urandom_range(0, 9) < 4);
      wb_tag_i         = TAG_W'($urandom_range(0, 7));
      wb_value_i       = {$urandom(), $urandom()};
      redirect_i       = ($urandom_range(0, 99) < 4);
      flush_i          = ($urandom_range(0, 99) < 3);
      settle();
      checks++; if (branch_valid_o !== exp_valid) begin
        errors++; $display("FAIL rand_valid@%0d: got %b expected %b", n, branch_valid_o, exp_valid); end
      checks++; if (disp_ready_o !== exp_ready || count_o !== exp_count) begin
        errors++; $display("FAIL rand_occupancy@%0d: got ready=%b count=%0d expected %b/%0d", n, disp_ready_o, count_o,
                           exp_ready, exp_count); end
      if (exp_valid) begin
        checks++; if (branch_pc_o !== exp_pc || branch_inst_o !== exp_inst || func_code_o !== exp_func ||
                      rs1_value_o !== exp_rs1 || rs2_value_o !== exp_rs2) begin
          errors++; $display("FAIL rand_data@%0d: got pc=%h inst=%h func=%h rs1=%h rs2=%h expected %h/%h/%h/%h/%h", n,
                             branch_pc_o, branch_inst_o, func_code_o, rs1_value_o, rs2_value_o,
                             exp_pc, exp_inst, exp_func, exp_rs1, exp_rs2); end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_jal();
    test_wakeup();
    test_back_to_back();
    test_full_stall();
    test_redirect();
    test_dispatch_bypass();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
